// File: rtl/bit_deser_pkg.sv
// Shared types and helpers for the bit deserializer: output-register states and
// the bit_count width derivation.
package bit_deser_pkg;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  localparam int unsigned MAX_WIDTH = 32;

  // bit_count must reach WIDTH-1; one spare bit keeps the width regular for all WIDTH.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bit_deserializer_if.sv
// Bundle of the serial input, word output handshake and status signals of bit_deserializer.
// slave is the deserializer side; master is the bit source plus word consumer.
interface bit_deserializer_if
  import bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CntW = cnt_width(WIDTH);

  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CntW-1:0]  bit_count;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    output bit_in, bit_valid, frame_start, word_ready, clr_ovf,
    input  word_out, word_valid, bit_count, overflow
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, word_ready, clr_ovf,
    output word_out, word_valid, bit_count, overflow
  );

endinterface

// File: rtl/deser_shift_reg.sv
// Collects qualified serial bits into a WIDTH-bit shift register and flags each
// completed word together with its combinationally assembled value.
module deser_shift_reg
  import bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CntW     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic [CntW-1:0]  bit_count
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last;

  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {shift_q[WIDTH-2:0], bit_in};
    assign fresh   = {{(WIDTH-1){1'b0}}, bit_in};
  end else begin : g_lsb_first
    assign shifted = {bit_in, shift_q[WIDTH-1:1]};
    assign fresh   = {bit_in, {(WIDTH-1){1'b0}}};
  end

  assign last      = (cnt_q == CntW'(WIDTH - 1));
  // A frame_start bit always opens a new word, so it can never complete one.
  assign word_done = bit_valid && !frame_start && last;
  assign word      = shifted;
  assign bit_count = cnt_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (bit_valid) begin
      if (frame_start) begin
        shift_d = fresh;
        cnt_d   = CntW'(1);
      end else begin
        shift_d = shifted;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
      end
    end else if (frame_start) begin
      shift_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel stage: packs WIDTH qualified bits per word into a single-entry
// valid/ready output register; words completed while it is blocked are dropped and flagged.
module bit_deserializer
  import bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,  // 2..MAX_WIDTH
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  bit_deserializer_if.slave  dif
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovf_q, ovf_d;
  logic             word_done;
  logic [WIDTH-1:0] word_new;

  deser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (dif.bit_in),
    .bit_valid   (dif.bit_valid),
    .frame_start (dif.frame_start),
    .word_done   (word_done),
    .word        (word_new),
    .bit_count   (dif.bit_count)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    if (dif.clr_ovf) begin
      ovf_d = 1'b0;
    end
    unique case (state_q)
      OUT_EMPTY: begin
        if (word_done) begin
          word_d  = word_new;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (dif.word_ready) begin
          // Consuming and refilling on the same edge keeps the stream bubble-free.
          if (word_done) begin
            word_d = word_new;
          end else begin
            state_d = OUT_EMPTY;
          end
        end else if (word_done) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= OUT_EMPTY;
      word_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dif.word_out   = word_q;
  assign dif.word_valid = (state_q == OUT_FULL);
  assign dif.overflow   = ovf_q;

endmodule
